// File: rtl/ps2_keycode_tracker.sv
// ps2_keycode_tracker
// -------------------
// Receives PS/2 Set-2 scan codes from a keyboard. It translates a fixed set of
// keys to USB HID usage codes and keeps up to four held keys in a 32-bit
// keycode bus. The bus format matches the USB keyboard path: one HID byte per
// slot, and 0x00 marks an empty slot.
//
// Ports:
//   Clk        system clock (50 MHz)
//   Reset      synchronous, active-low reset
//   PS2_CLK    keyboard clock, asynchronous, idle high
//   PS2_DATA   keyboard data, asynchronous, idle high
//   keycode    {slot3, slot2, slot1, slot0}, one HID byte per slot
//   key_event  one-cycle pulse in the first cycle a changed keycode is visible
//   frame_err  one-cycle pulse on a parity error, stop-bit error or timeout
//   state_dbg  current receive FSM state (0 = IDLE, 1 = DATA, 2 = PARITY,
//              3 = STOP)
//
// Timing, where E is the cycle that detects a synchronized PS2_CLK fall:
//   - PS2_DATA is sampled in E.
//   - byte_ready or frame_err is high in E+1.
//   - keycode and key_event change at the end of E+1, so they are visible
//     from E+2.
module ps2_keycode_tracker #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [31:0] keycode,
    output logic        key_event,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and falling-edge detect.
    // The synchronizer stages reset to 1 (the line idle level), so leaving
    // reset never produces a false falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_e;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= PS2_CLK;
            data_sync[0] <= PS2_DATA;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall_e = clk_prev & ~clk_s;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t       state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shift_q, shift_n;
    logic            par_q, par_n;
    logic [TW-1:0]   to_cnt, to_cnt_n;
    logic            byte_ready, byte_ready_n;
    logic            frame_err_n;
    logic            timeout_hit;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            to_cnt     <= '0;
            byte_ready <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            par_q      <= par_n;
            to_cnt     <= to_cnt_n;
            byte_ready <= byte_ready_n;
            frame_err  <= frame_err_n;
        end
    end

    // A frame edge in the same cycle as the timeout takes priority, and the
    // counter clears.
    assign timeout_hit = (state != IDLE) && !fall_e && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_q;
        par_n        = par_q;
        to_cnt_n     = to_cnt + TW'(1);
        byte_ready_n = 1'b0;
        frame_err_n  = 1'b0;

        if (state == IDLE || fall_e) begin
            to_cnt_n = '0;
        end

        if (timeout_hit) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
            to_cnt_n    = '0;
        end else if (fall_e) begin
            case (state)
                IDLE: begin
                    // A high level at the first edge is a glitch, not a start bit.
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shift_n   = {data_s, shift_q[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = data_s;
                    state_n = STOP;
                end
                STOP: begin
                    if (data_s && (^{shift_q, par_q})) begin
                        byte_ready_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Byte decode and key slots.
    // shift_q still holds the received byte in the byte_ready cycle. The
    // next frame cannot shift in new data until several edges later.
    // ------------------------------------------------------------------
    function automatic logic [7:0] to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        case ({ext, code})
            9'h05A:  hid = 8'h28;  // Enter
            9'h01D:  hid = 8'h1A;  // W
            9'h01C:  hid = 8'h04;  // A
            9'h01B:  hid = 8'h16;  // S
            9'h023:  hid = 8'h07;  // D
            9'h029:  hid = 8'h2C;  // Space
            9'h175:  hid = 8'h52;  // Up
            9'h172:  hid = 8'h51;  // Down
            9'h16B:  hid = 8'h50;  // Left
            9'h174:  hid = 8'h4F;  // Right
            default: hid = 8'h00;
        endcase
        return hid;
    endfunction

    logic        ext_q, ext_n;
    logic        brk_q, brk_n;
    logic [7:0]  hid;
    logic        present;
    logic        placed;
    logic [31:0] kc_n;

    assign hid = to_hid(ext_q, shift_q);

    always_comb begin
        present = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[i*8 +: 8] == hid) begin
                present = 1'b1;
            end
        end
    end

    always_comb begin
        kc_n   = keycode;
        ext_n  = ext_q;
        brk_n  = brk_q;
        placed = 1'b0;

        if (frame_err) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (byte_ready) begin
            if (shift_q == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_n = 1'b1;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (hid != 8'h00) begin
                    if (brk_q) begin
                        // Release: empty every matching slot. The other slots
                        // keep their positions; there is no compaction.
                        for (int i = 0; i < 4; i++) begin
                            if (keycode[i*8 +: 8] == hid) begin
                                kc_n[i*8 +: 8] = 8'h00;
                            end
                        end
                    end else if (!present) begin
                        // Press: use the lowest free slot. When all four slots
                        // are full, the key is dropped.
                        for (int i = 0; i < 4; i++) begin
                            if (!placed && keycode[i*8 +: 8] == 8'h00) begin
                                kc_n[i*8 +: 8] = hid;
                                placed         = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            keycode   <= 32'd0;
            key_event <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            keycode   <= kc_n;
            key_event <= (kc_n != keycode);
            ext_q     <= ext_n;
            brk_q     <= brk_n;
        end
    end

endmodule
